// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Round-robin arbiter and sequencer that shares one external 8-bit registered
// adder (one-cycle latency, not reset) among N_REQ requesters. One operand
// pair is accepted at a time, held at the adder, and the captured sum is
// returned with the owner's ID over a backpressured response channel.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [N_REQ]    per-requester request valid
//   req_a      in   [8*N_REQ]  operand A, requester i at [8i+7:8i]
//   req_b      in   [8*N_REQ]  operand B, packed like req_a
//   req_ready  out  [N_REQ]    one-hot accept, combinational, IDLE only
//   add_a      out  [8]        registered operand A to the adder
//   add_b      out  [8]        registered operand B to the adder
//   add_c      in   [8]        adder result, valid one cycle after operands
//   rsp_valid  out             response valid (RESP state)
//   rsp_id     out  [ID_W]     requester that owns rsp_data
//   rsp_data   out  [8]        (a + b) mod 256
//   rsp_ready  in              response consumer ready
//   busy       out             high in any state other than IDLE
//   ops_done   out  [16]       completed response handshakes, wraps
// -----------------------------------------------------------------------------
module adder_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    input  logic [7:0]           add_c,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_data,
    input  logic                 rsp_ready,
    output logic                 busy,
    output logic [15:0]          ops_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cur_id;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] grant_nxt_ptr;
    logic [7:0]      sel_a, sel_b;
    logic            accept;
    logic            rsp_fire;

    // Round-robin search: first asserted requester at or after rr_ptr, with
    // wrap. Only indices below N_REQ are ever examined, so unused bits of a
    // non-power-of-two ID space never reach the grant.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned, which would infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    // Operand mux with constant slices only: no variable part-select can
    // reach past the packed buses.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = req_a[8*i +: 8];
                sel_b = req_b[8*i +: 8];
            end
        end
    end

    assign grant_nxt_ptr = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign accept        = (state == IDLE) && grant_found;
    assign rsp_fire      = (state == RESP) && rsp_ready;
    assign rsp_valid     = (state == RESP);
    assign busy          = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_found) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            cur_id   <= '0;
            add_a    <= '0;
            add_b    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            ops_done <= '0;
        end else begin
            if (accept) begin
                add_a  <= sel_a;
                add_b  <= sel_b;
                cur_id <= grant_idx;
                rr_ptr <= grant_nxt_ptr;
            end
            // add_c is only trusted here; a stale sum left in the unreset
            // adder after a mid-operation reset is never captured.
            if (state == CAPTURE) begin
                rsp_data <= add_c;
                rsp_id   <= cur_id;
            end
            if (rsp_fire) ops_done <= ops_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//
// Directed bench for adder_arbiter with N_REQ = 4. Models the external
// registered adder, drives inputs on the falling edge and samples outputs
// 1 ns after it.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [7:0]     add_a, add_b, add_c;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_data;
    logic           rsp_ready;
    logic           busy;
    logic [15:0]    ops_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_ops  = 16'd0;

    always #5 clk = ~clk;

    // External adder: one-cycle registered sum, no reset.
    always @(posedge clk) add_c <= add_a + add_b;

    adder_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]   = 1'b1;
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ops = 16'd0;
    endtask

    // One complete operation from requester i with rsp_ready held high.
    task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] sum);
        @(negedge clk);
        req_valid = '0;
        set_req(i, a, b);
        #1;
        n_checks++;
        if (req_ready !== 4'(1 << i)) begin
            n_fail++;
            $display("FAIL op_grant req%0d: got %b want %b", i, req_ready, 4'(1 << i));
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++;
        if ({add_a, add_b, busy, req_ready} !== {a, b, 1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL op_issue req%0d: got a=%h b=%h busy=%b rdy=%b want a=%h b=%h busy=1 rdy=0000",
                     i, add_a, add_b, busy, req_ready, a, b);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL op_capture req%0d: got valid=%b busy=%b want valid=0 busy=1",
                     i, rsp_valid, busy);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(i), sum}) begin
            n_fail++;
            $display("FAIL op_resp req%0d: got valid=%b id=%0d data=%h want valid=1 id=%0d data=%h",
                     i, rsp_valid, rsp_id, rsp_data, i, sum);
        end
        @(negedge clk);
        #1;
        exp_ops = exp_ops + 16'd1;
        n_checks++;
        if ({ops_done, busy, rsp_valid} !== {exp_ops, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL op_done req%0d: got ops=%h busy=%b valid=%b want ops=%h busy=0 valid=0",
                     i, ops_done, busy, rsp_valid, exp_ops);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if ({req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy, ops_done} !== '0) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b a=%h b=%h valid=%b id=%0d data=%h busy=%b ops=%h want all zero",
                     name, req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy, ops_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset_values");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        run_op(2, 8'h12, 8'h34, 8'h46);
    endtask

    task automatic test_overflow();
        run_op(0, 8'hF0, 8'h25, 8'h15);
    endtask

    task automatic test_round_robin();
        logic [7:0] ta [N] = '{8'h11, 8'h22, 8'h33, 8'hC4};
        logic [7:0] tb [N] = '{8'h01, 8'h02, 8'h03, 8'h50};
        logic [7:0] ts [N] = '{8'h12, 8'h24, 8'h36, 8'h14};
        int g_id  [5];
        int g_cyc [5];
        int ng   = 0;
        int last = -1;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, ta[i], tb[i]);
        for (int c = 0; c < 40 && ng < 5; c++) begin
            #1;
            if (rsp_valid && last >= 0) begin
                n_checks++;
                if (rsp_data !== ts[last]) begin
                    n_fail++;
                    $display("FAIL rr_data req%0d: got %h want %h", last, rsp_data, ts[last]);
                end
            end
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) g_id[ng] = i;
                g_cyc[ng] = c;
                last = g_id[ng];
                ng++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        n_checks++;
        if (ng != 5) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d grants want 5", ng);
        end
        for (int k = 0; k < ng; k++) begin
            n_checks++;
            if (g_id[k] != k % N || g_cyc[k] != 4 * k) begin
                n_fail++;
                $display("FAIL rr_order grant%0d: got req%0d at cycle %0d want req%0d at cycle %0d",
                         k, g_id[k], g_cyc[k], k % N, 4 * k);
            end
        end
        // Let the fifth operation drain.
        for (int c = 0; c < 10 && (busy || ops_done != 16'd5); c++) @(negedge clk);
        #1;
        exp_ops = 16'd5;
        n_checks++;
        if ({ops_done, busy} !== {exp_ops, 1'b0}) begin
            n_fail++;
            $display("FAIL rr_drain: got ops=%h busy=%b want ops=%h busy=0", ops_done, busy, exp_ops);
        end
    endtask

    task automatic test_backpressure();
        // rr_ptr is 1 here; requester 3 competes and must not win while stalled.
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(1, 8'h80, 8'h90);
        set_req(3, 8'h05, 8'h06);
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_grant: got %b want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1000;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_data, req_ready, busy, ops_done} !==
                {1'b1, 2'd1, 8'h10, 4'b0000, 1'b1, exp_ops}) begin
                n_fail++;
                $display("FAIL bp_hold cycle%0d: got valid=%b id=%0d data=%h rdy=%b busy=%b ops=%h want 1 1 10 0000 1 %h",
                         s, rsp_valid, rsp_id, rsp_data, req_ready, busy, ops_done, exp_ops);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'h10}) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b id=%0d data=%h want 1 1 10",
                     rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        #1;
        exp_ops = exp_ops + 16'd1;
        n_checks++;
        if ({ops_done, busy} !== {exp_ops, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_done: got ops=%h busy=%b want ops=%h busy=0", ops_done, busy, exp_ops);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        // Grant requester 1 so rr_ptr would point at 2 without the reset.
        run_op(1, 8'h21, 8'h03, 8'h24);
        @(negedge clk);
        set_req(1, 8'h01, 8'h02);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset_values");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            #1;
            if (rsp_valid) seen++;
        end
        n_checks++;
        if (seen != 0 || ops_done !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_no_rsp: got %0d valid cycles ops=%h want 0 and 0000", seen, ops_done);
        end
        exp_ops = 16'd0;
        @(negedge clk);
        set_req(1, 8'h40, 8'h41);
        set_req(3, 8'h50, 8'h51);
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL midreset_ptr: got %b want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'h81}) begin
            n_fail++;
            $display("FAIL midreset_resp: got valid=%b id=%0d data=%h want 1 1 81",
                     rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        exp_ops = 16'd1;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.ops_done = 16'hFFFF;
        #1;
        release dut.ops_done;
        #1;
        exp_ops = 16'hFFFF;
        n_checks++;
        if (ops_done !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got %h want ffff", ops_done);
        end
        run_op(3, 8'hFF, 8'hFF, 8'hFE);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one 8-bit registered adder (one-cycle latency, no reset) among `N_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and drives held operands into the adder. It captures the sum and returns it with the requester ID over a backpressured response channel. It sits between the requesting blocks and the single adder instance.

## Interface
- `N_REQ`, default 4, number of requesters (2..8); `ID_W = $clog2(N_REQ)` is derived.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_a`  in  8*N_REQ  operand A; requester i occupies bits [8i+7:8i].
- `req_b`  in  8*N_REQ  operand B, packed like `req_a`.
- `req_ready`  out  N_REQ  one-hot grant/accept; combinational.
- `add_a`  out  8  operand A to the adder; registered.
- `add_b`  out  8  operand B to the adder; registered.
- `add_c`  in  8  adder result, valid one cycle after operands.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  ID_W  index of the requester that owns `rsp_data`.
- `rsp_data`  out  8  sum, (a+b) mod 256.
- `rsp_ready`  in  1  response consumer ready.
- `busy`  out  1  high in any state other than IDLE.
- `ops_done`  out  16  count of completed response handshakes; wraps.

## Operation
- **FSM states:** IDLE → ISSUE → CAPTURE → RESP → IDLE.
- **IDLE:**
  - If any `req_valid` is set, grant g = first asserted index at or after `rr_ptr`, searching upward with wrap.
  - `req_ready[g]`=1 combinationally; the request is accepted in that cycle.
  - On the edge: `add_a`/`add_b` ← operands of g; `cur_id` ← g; `rr_ptr` ← (g+1) mod N_REQ; go to ISSUE.
  - If no `req_valid` is set, stay in IDLE and leave `rr_ptr` unchanged.
- **ISSUE:** operands are stable at the adder, which registers the sum on this edge. Go to CAPTURE.
- **CAPTURE:** `add_c` holds the sum. On the edge: `rsp_data` ← `add_c`; `rsp_id` ← `cur_id`; go to RESP.
- **RESP:**
  - `rsp_valid`=1.
  - If `rsp_ready`=1: handshake completes, `ops_done` increments, go to IDLE.
  - If `rsp_ready`=0: hold `rsp_valid`, `rsp_id` and `rsp_data` stable.
- `req_ready` is all-zero outside IDLE. At most one bit is ever set.
- A requester may drop `req_valid` at any time before acceptance. Only the accept cycle is sampled.
- `add_a`/`add_b` hold their last values in all states other than IDLE-accept.
- **Arithmetic:** 8-bit wrap; carry is discarded. `ops_done` wraps 0xFFFF → 0x0000.
- **Reset values:** state=IDLE, `rr_ptr`=0, `add_a`=`add_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0, `ops_done`=0, `req_ready`=0.
- **Reset mid-operation:** the in-flight operation is dropped with no response. The stale `add_c` (the adder is not reset) is ignored because capture happens only in CAPTURE.
- **Out-of-range requests:** `req_valid` bits for requesters ≥ N_REQ do not exist. No X is propagated from unused packed slices.

## Timing
- Request accepted in cycle T (`req_ready`=1).
- `add_a`/`add_b` valid from T+1.
- `add_c` valid at T+2.
- `rsp_valid` first high at T+3.
- Minimum 4 cycles per operation with `rsp_ready` held high. Next accept at T+4 at the earliest.
- Backpressure extends RESP one cycle per cycle of `rsp_ready`=0. No request is accepted while stalled.
- `busy` is asserted from T+1 through the RESP handshake cycle inclusive.
- **Fairness:** a continuously requesting client waits at most N_REQ−1 operations between grants.

## Test plan
- **Reset then single request:** `req_valid[2]`=1, a=0x12, b=0x34 → `req_ready`=0b0100 in T, `rsp_valid` at T+3 with `rsp_id`=2, `rsp_data`=0x46, `ops_done`=1.
- **Overflow:** a=0xF0, b=0x25 from requester 0 → `rsp_data`=0x15.
- **Round-robin:** all four requesters held valid with `rsp_ready`=1 → grant order 0,1,2,3,0. Accepts exactly 4 cycles apart.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`/`rsp_id`/`rsp_data` stable for all 5 cycles, `req_ready`=0, `busy`=1. Response completes on the cycle `rsp_ready` rises.
- **Reset mid-operation:** assert `rst_n`=0 in CAPTURE → all outputs return to reset values immediately. No response is produced. The next request after release is granted starting from requester 0.
- **Counter wrap:** preload the scenario to 65535 operations (or force `ops_done`=0xFFFF) and complete one handshake → `ops_done`=0x0000.
